id_ex_hazard_stage: RTL and testbench

// - ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush.
// - Sits between decode and execute. Drives ex_rs1/ex_rs2 to forwarding_unit Rs1/Rs2.
// - Drives ex_rd/ex_reg_write into EX/MEM. Drives pc_write_en/if_id_write_en upstream.

---
 rtl/id_ex_hazard_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ============================================================================
// id_ex_hazard_stage : ID/EX pipeline register with load-use stall and flush.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_hazard_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_uses_rs2,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [7:0]        id_ctrl,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [7:0]        ex_ctrl,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int C_MEM_READ_BIT = 6;

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_hazard;
  logic w_stall;

  assign w_rs1_match = (ex_rd == id_rs1);
  assign w_rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
  assign w_hazard    = ex_valid && ex_ctrl[C_MEM_READ_BIT] && (ex_rd != '0) &&
                       id_valid && (w_rs1_match || w_rs2_match);
  // A flush kills the dependent instruction anyway, so it never needs to stall.
  assign w_stall        = w_hazard && !flush;
  assign pc_write_en    = !w_stall;
  assign if_id_write_en = !w_stall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_valid  <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
      ex_ctrl   <= '0;
    end else if (enable) begin
      if (flush || w_hazard) begin
        ex_valid  <= 1'b0;
        ex_rs1    <= '0;
        ex_rs2    <= '0;
        ex_rd     <= '0;
        ex_rdata1 <= '0;
        ex_rdata2 <= '0;
        ex_imm    <= '0;
        ex_pc     <= '0;
        ex_ctrl   <= '0;
      end else begin
        ex_valid  <= id_valid;
        ex_rs1    <= id_rs1;
        ex_rs2    <= id_rs2;
        // An empty slot must never look like a producer to the forwarding unit.
        ex_rd     <= id_valid ? id_rd : '0;
        ex_rdata1 <= id_rdata1;
        ex_rdata2 <= id_rdata2;
        ex_imm    <= id_imm;
        ex_pc     <= id_pc;
        ex_ctrl   <= id_valid ? id_ctrl : 8'h00;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (enable) begin
      if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  assign bubble_cnt = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
// ============================================================================
// tb_id_ex_hazard_stage : table-driven bench for id_ex_hazard_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_stage;

  logic        clk;
  logic        arst;
  logic        enable;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs2;
  logic [63:0] id_rdata1;
  logic [63:0] id_rdata2;
  logic [63:0] id_imm;
  logic [63:0] id_pc;
  logic [7:0]  id_ctrl;
  logic        ex_valid;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [63:0] ex_rdata1;
  logic [63:0] ex_rdata2;
  logic [63:0] ex_imm;
  logic [63:0] ex_pc;
  logic [7:0]  ex_ctrl;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;

  int checks;
  int passes;

  id_ex_hazard_stage #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .arst(arst), .enable(enable), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs2(id_uses_rs2), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_ctrl(ex_ctrl), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, fl, v, u;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
    logic [63:0] d;
    logic        x_we, x_v;
    logic [4:0]  x_rs1, x_rs2, x_rd;
    logic [7:0]  x_ctrl;
    logic [63:0] x_d;
    logic [31:0] x_bub, x_fl;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic en, fl, v, u, input logic [4:0] rs1, rs2, rd,
                              input logic [7:0] ctrl, input logic [63:0] d,
                              input logic x_we, x_v, input logic [4:0] x_rs1, x_rs2, x_rd,
                              input logic [7:0] x_ctrl, input logic [63:0] x_d,
                              input logic [31:0] x_bub, x_fl);
    vec_t t;
    t.en = en; t.fl = fl; t.v = v; t.u = u; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.ctrl = ctrl; t.d = d; t.x_we = x_we; t.x_v = x_v; t.x_rs1 = x_rs1;
    t.x_rs2 = x_rs2; t.x_rd = x_rd; t.x_ctrl = x_ctrl; t.x_d = x_d;
    t.x_bub = x_bub; t.x_fl = x_fl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Companion datapath fields are derived from rdata1 so they are all checked.
  task automatic drive(input logic en, fl, v, u, input logic [4:0] rs1, rs2, rd,
                       input logic [7:0] ctrl, input logic [63:0] d);
    enable = en; flush = fl; id_valid = v; id_uses_rs2 = u;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    id_rdata1 = d; id_rdata2 = ~d; id_imm = d + 64'd1; id_pc = d << 2;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] bub, input logic [31:0] fl);
`ifdef HAZARD_STATS_EN
    chk({tag, " bubble_cnt"}, {32'd0, bubble_cnt}, {32'd0, bub});
    chk({tag, " flush_cnt"}, {32'd0, flush_cnt}, {32'd0, fl});
`else
    chk({tag, " bubble_cnt"}, {32'd0, bubble_cnt}, 64'd0);
    chk({tag, " flush_cnt"}, {32'd0, flush_cnt}, 64'd0);
`endif
  endtask

  initial begin
    checks = 0;
    passes = 0;
    arst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 64'd0);

    //            en fl v  u  rs1 rs2 rd  ctrl   d        we xv xrs1 xrs2 xrd xctrl x_d   bub fl
    tbl[0]  = mk(1, 0, 1, 1, 3,  4,  5,  8'h80, 64'hA5,  1, 1, 3,  4,  5,  8'h80, 64'hA5, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 1,  0,  5,  8'hC0, 64'h11,  1, 1, 1,  0,  5,  8'hC0, 64'h11, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 5,  1,  6,  8'h80, 64'h22,  0, 0, 0,  0,  0,  8'h00, 64'h0,  1, 0);
    tbl[3]  = mk(1, 0, 1, 1, 5,  1,  6,  8'h80, 64'h22,  1, 1, 5,  1,  6,  8'h80, 64'h22, 1, 0);
    tbl[4]  = mk(1, 0, 1, 0, 2,  0,  0,  8'hC0, 64'h33,  1, 1, 2,  0,  0,  8'hC0, 64'h33, 1, 0);
    tbl[5]  = mk(1, 0, 1, 1, 0,  0,  8,  8'h80, 64'h44,  1, 1, 0,  0,  8,  8'h80, 64'h44, 1, 0);
    tbl[6]  = mk(1, 0, 1, 0, 1,  0,  7,  8'hC0, 64'h55,  1, 1, 1,  0,  7,  8'hC0, 64'h55, 1, 0);
    tbl[7]  = mk(1, 0, 1, 0, 2,  7,  9,  8'h80, 64'h66,  1, 1, 2,  7,  9,  8'h80, 64'h66, 1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 3,  0,  10, 8'hC0, 64'h77,  1, 1, 3,  0,  10, 8'hC0, 64'h77, 1, 0);
    tbl[9]  = mk(1, 0, 1, 1, 4,  10, 11, 8'h80, 64'h88,  0, 0, 0,  0,  0,  8'h00, 64'h0,  2, 0);
    tbl[10] = mk(1, 0, 1, 0, 1,  0,  12, 8'hC0, 64'h99,  1, 1, 1,  0,  12, 8'hC0, 64'h99, 2, 0);
    tbl[11] = mk(1, 1, 1, 0, 12, 0,  13, 8'h80, 64'hAA,  1, 0, 0,  0,  0,  8'h00, 64'h0,  2, 1);
    tbl[12] = mk(1, 0, 1, 0, 6,  0,  14, 8'h80, 64'hAB,  1, 1, 6,  0,  14, 8'h80, 64'hAB, 2, 1);
    tbl[13] = mk(0, 0, 1, 1, 7,  3,  15, 8'hFF, 64'hB1,  1, 1, 6,  0,  14, 8'h80, 64'hAB, 2, 1);
    tbl[14] = mk(0, 0, 1, 1, 8,  4,  16, 8'hFE, 64'hB2,  1, 1, 6,  0,  14, 8'h80, 64'hAB, 2, 1);
    tbl[15] = mk(0, 0, 1, 1, 9,  5,  17, 8'hFD, 64'hB3,  1, 1, 6,  0,  14, 8'h80, 64'hAB, 2, 1);
    tbl[16] = mk(1, 0, 1, 0, 1,  0,  20, 8'hC0, 64'h12,  1, 1, 1,  0,  20, 8'hC0, 64'h12, 2, 1);
    tbl[17] = mk(0, 0, 1, 0, 20, 0,  21, 8'h80, 64'h34,  0, 1, 1,  0,  20, 8'hC0, 64'h12, 2, 1);
    tbl[18] = mk(0, 1, 1, 0, 20, 0,  21, 8'h80, 64'h34,  1, 1, 1,  0,  20, 8'hC0, 64'h12, 2, 1);
    tbl[19] = mk(1, 0, 0, 0, 20, 0,  0,  8'h80, 64'h34,  1, 0, 20, 0,  0,  8'h00, 64'h34, 2, 1);

    repeat (2) @(negedge clk);
    chk("reset ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("reset ex_ctrl", {56'd0, ex_ctrl}, 64'd0);
    chk("reset pc_write_en", {63'd0, pc_write_en}, 64'd1);
    chk_cnt("reset", 32'd0, 32'd0);
    arst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].u, tbl[i].rs1, tbl[i].rs2,
            tbl[i].rd, tbl[i].ctrl, tbl[i].d);
      #1;
      chk($sformatf("v%0d pc_write_en", i), {63'd0, pc_write_en}, {63'd0, tbl[i].x_we});
      chk($sformatf("v%0d if_id_write_en", i), {63'd0, if_id_write_en}, {63'd0, tbl[i].x_we});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), {63'd0, ex_valid}, {63'd0, tbl[i].x_v});
      chk($sformatf("v%0d ex_rs1", i), {59'd0, ex_rs1}, {59'd0, tbl[i].x_rs1});
      chk($sformatf("v%0d ex_rs2", i), {59'd0, ex_rs2}, {59'd0, tbl[i].x_rs2});
      chk($sformatf("v%0d ex_rd", i), {59'd0, ex_rd}, {59'd0, tbl[i].x_rd});
      chk($sformatf("v%0d ex_ctrl", i), {56'd0, ex_ctrl}, {56'd0, tbl[i].x_ctrl});
      chk($sformatf("v%0d ex_rdata1", i), ex_rdata1, tbl[i].x_d);
      chk($sformatf("v%0d ex_rdata2", i), ex_rdata2, (tbl[i].x_d == 64'd0) ? 64'd0 : ~tbl[i].x_d);
      chk($sformatf("v%0d ex_imm", i), ex_imm, (tbl[i].x_d == 64'd0) ? 64'd0 : tbl[i].x_d + 64'd1);
      chk($sformatf("v%0d ex_pc", i), ex_pc, tbl[i].x_d << 2);
      chk_cnt($sformatf("v%0d", i), tbl[i].x_bub, tbl[i].x_fl);
    end

    // Reset asserted mid-cycle while a load-use stall is pending.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5, 8'hC0, 64'h5A);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6, 8'h80, 64'h6B);
    #1;
    chk("midstall pc_write_en", {63'd0, pc_write_en}, 64'd0);
    #1;
    arst = 1'b1;
    #1;
    chk("async ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("async ex_rd", {59'd0, ex_rd}, 64'd0);
    chk("async ex_ctrl", {56'd0, ex_ctrl}, 64'd0);
    chk("async ex_rdata1", ex_rdata1, 64'd0);
    chk("async pc_write_en", {63'd0, pc_write_en}, 64'd1);
    chk("async if_id_write_en", {63'd0, if_id_write_en}, 64'd1);
    chk_cnt("async", 32'd0, 32'd0);
    @(negedge clk);
    arst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
